// File: rtl/uflash_pkg.sv
// Shared definitions for the user-flash page writer: FSM states, bus strobe
// encodings, page geometry and error codes.
// Optional build macro: UFLASH_VERIFY_EN adds the readback VERIFY state.
package uflash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_ERASE,
    ST_FETCH,
    ST_PROG,
`ifdef UFLASH_VERIFY_EN
    ST_VERIFY,
`endif
    ST_COOL
  } state_t;

  localparam logic [3:0] WSTRB_READ  = 4'b0000;
  localparam logic [3:0] WSTRB_ERASE = 4'b0001;
  localparam logic [3:0] WSTRB_PROG  = 4'b1111;

  localparam int unsigned WORDS_PER_PAGE = 512;
  localparam int unsigned PAGE_SHIFT     = 9;

  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_PAGE   = 2'd1;
  localparam logic [1:0] ERR_LEN    = 2'd2;
  localparam logic [1:0] ERR_VERIFY = 2'd3;

  // Word address inside a page; widx < 512 so the page field never carries.
  function automatic logic [14:0] word_addr(input logic [5:0] pg, input logic [9:0] widx);
    return {pg, widx[PAGE_SHIFT-1:0]};
  endfunction

endpackage

// File: rtl/uflash_gap_timer.sv
// Cooldown down-counter: load sets it to GAP_CLKS, it then counts to zero and
// holds there. expired is high whenever the count is zero.
module uflash_gap_timer #(
  parameter int unsigned GAP_CLKS = 54000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  output logic expired
);

  localparam int unsigned CW = (GAP_CLKS < 1) ? 1 : $clog2(GAP_CLKS + 1);

  logic [CW-1:0] count;

  // Load on entry to cooldown, otherwise count down and stick at zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(GAP_CLKS);
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/uflash_page_writer.sv
// User-flash page writer: erases one page, then programs up to 512 words taken
// from a valid/ready stream, and enforces a cooldown before returning to idle.
// Optional build macro: UFLASH_VERIFY_EN reads back each programmed word and
// aborts the job on a mismatch.
module uflash_page_writer
  import uflash_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 5400000,
  parameter int unsigned GAP_MS    = 10,
  parameter int unsigned NUM_PAGES = 38
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [5:0]  page,
  input  logic [9:0]  len,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic        f_sel,
  output logic [3:0]  f_wstrb,
  output logic [14:0] f_addr,
  output logic [31:0] f_wdata,
  input  logic        f_ready,
  input  logic [31:0] f_rdata
);

  localparam int unsigned GAP_CLKS = CLK_FREQ * GAP_MS / 1000;

  state_t      state, state_n;
  logic [5:0]  page_q;
  logic [9:0]  len_q;
  logic [9:0]  widx;
  logic        aborted;

  logic        start_ok, bad_page, bad_len, op_done, last_word, verify_bad, advance;
  logic        launch, cool_load, cool_expired;
  logic [3:0]  launch_wstrb;
  logic [14:0] launch_addr;

  // A start coinciding with the done/err pulse is still part of the old job.
  assign start_ok  = start & ~done & ~err;
  assign op_done   = f_sel & f_ready;
  assign bad_page  = ({26'd0, page_q} >= NUM_PAGES);
  assign bad_len   = (len_q > 10'd512);
  assign last_word = ((widx + 10'd1) == len_q);

`ifdef UFLASH_VERIFY_EN
  assign verify_bad = (f_rdata != f_wdata);
  assign advance    = (state == ST_VERIFY) && op_done && !verify_bad;
`else
  logic unused_rdata;
  assign unused_rdata = ^f_rdata;
  assign verify_bad   = 1'b0;
  assign advance      = (state == ST_PROG) && op_done;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_n;
  end

  // Next-state decode; bus states leave only on a completed transfer.
  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE:   if (start_ok) state_n = ST_CHECK;
      ST_CHECK:  state_n = (bad_page || bad_len) ? ST_IDLE : ST_ERASE;
      ST_ERASE:  if (op_done) state_n = (len_q == 10'd0) ? ST_COOL : ST_FETCH;
      ST_FETCH:  if (in_valid) state_n = ST_PROG;
`ifdef UFLASH_VERIFY_EN
      ST_PROG:   if (op_done) state_n = ST_VERIFY;
      ST_VERIFY: if (op_done) state_n = (verify_bad || last_word) ? ST_COOL : ST_FETCH;
`else
      ST_PROG:   if (op_done) state_n = last_word ? ST_COOL : ST_FETCH;
`endif
      ST_COOL:   if (cool_expired) state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  // Moore outputs plus the request to issue a new bus transfer.
  always_comb begin
    busy         = (state != ST_IDLE);
    in_ready     = (state == ST_FETCH);
    launch       = 1'b0;
    launch_wstrb = WSTRB_READ;
    launch_addr  = word_addr(page_q, widx);
    cool_load    = (state_n == ST_COOL) && (state != ST_COOL);
    unique case (state)
      ST_ERASE: begin
        launch       = ~f_sel;
        launch_wstrb = WSTRB_ERASE;
        launch_addr  = {page_q, 9'd0};
      end
      ST_PROG: begin
        launch       = ~f_sel;
        launch_wstrb = WSTRB_PROG;
      end
`ifdef UFLASH_VERIFY_EN
      ST_VERIFY: begin
        launch       = ~f_sel;
        launch_wstrb = WSTRB_READ;
      end
`endif
      default: ;
    endcase
  end

  // Bus drive: sel rises one cycle after entering a bus state and drops on
  // the completing edge, so the responder always sees an idle cycle between ops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      f_sel   <= 1'b0;
      f_wstrb <= 4'd0;
      f_addr  <= 15'd0;
      f_wdata <= 32'd0;
    end else begin
      if (op_done) begin
        f_sel <= 1'b0;
      end else if (launch) begin
        f_sel   <= 1'b1;
        f_wstrb <= launch_wstrb;
        f_addr  <= launch_addr;
      end
      if (state == ST_FETCH && in_valid) f_wdata <= in_data;
    end
  end

  // Job parameters captured with an accepted start.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && start_ok) begin
      page_q <= page;
      len_q  <= len;
    end
  end

  // Word index, abort flag, error code and completion pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      widx     <= 10'd0;
      aborted  <= 1'b0;
      err_code <= ERR_NONE;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= (state == ST_COOL) && cool_expired && !aborted;
      err  <= ((state == ST_CHECK) && (bad_page || bad_len)) ||
              ((state == ST_COOL) && cool_expired && aborted);
      if (state == ST_IDLE && start_ok) begin
        err_code <= ERR_NONE;
        aborted  <= 1'b0;
      end else if (state == ST_CHECK) begin
        if (bad_page)     err_code <= ERR_PAGE;
        else if (bad_len) err_code <= ERR_LEN;
      end
`ifdef UFLASH_VERIFY_EN
      if (state == ST_VERIFY && op_done && verify_bad) begin
        err_code <= ERR_VERIFY;
        aborted  <= 1'b1;
      end
`endif
      if (state == ST_ERASE && op_done) widx <= 10'd0;
      else if (advance)                 widx <= widx + 10'd1;
    end
  end

  uflash_gap_timer #(
    .GAP_CLKS(GAP_CLKS)
  ) u_gap_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (cool_load),
    .expired (cool_expired)
  );

endmodule

// File: tb/tb_uflash_page_writer.sv
// Directed bench for uflash_page_writer with a behavioural flash responder.
// A reduced clock frequency keeps each cooldown short (GAP clocks).
module tb_uflash_page_writer;

  localparam int CLK_FREQ_TB = 540000;
  localparam int GAP_MS_TB   = 10;
  localparam int GAP         = CLK_FREQ_TB * GAP_MS_TB / 1000;
  localparam int LAT         = 3;
`ifdef UFLASH_VERIFY_EN
  localparam int VSTEP = 2;
`else
  localparam int VSTEP = 1;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  page = 6'd0;
  logic [9:0]  len = 10'd0;
  logic [31:0] in_data = 32'd0;
  logic        in_valid = 1'b0;
  logic        in_ready, busy, done, err, f_sel;
  logic [1:0]  err_code;
  logic [3:0]  f_wstrb;
  logic [14:0] f_addr;
  logic [31:0] f_wdata;
  logic        f_ready;
  logic [31:0] f_rdata;

  int vec = 0;
  int miss = 0;

  always #5 clk = ~clk;

  uflash_page_writer #(
    .CLK_FREQ (CLK_FREQ_TB),
    .GAP_MS   (GAP_MS_TB),
    .NUM_PAGES(38)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .page(page), .len(len),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .busy(busy),
    .done(done), .err(err), .err_code(err_code), .f_sel(f_sel), .f_wstrb(f_wstrb),
    .f_addr(f_addr), .f_wdata(f_wdata), .f_ready(f_ready), .f_rdata(f_rdata)
  );

  // Flash responder model: logs each op when sel is seen, answers after LAT
  // clocks, then spends one idle cycle ignoring sel.
  int          op_n = 0;
  logic [3:0]  op_wstrb [0:63];
  logic [14:0] op_addr  [0:63];
  logic [31:0] op_wdata [0:63];
  int          m_phase, m_cnt;
  int          stab_err = 0;
  logic [31:0] m_last;
  logic [14:0] corrupt_addr = 15'h7fff;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_phase <= 0;
      m_cnt   <= 0;
      f_ready <= 1'b0;
      f_rdata <= 32'd0;
    end else begin
      f_ready <= 1'b0;
      case (m_phase)
        0: if (f_sel) begin
          if (op_n < 64) begin
            op_wstrb[op_n] <= f_wstrb;
            op_addr[op_n]  <= f_addr;
            op_wdata[op_n] <= f_wdata;
          end
          op_n    <= op_n + 1;
          m_phase <= 1;
          m_cnt   <= LAT;
        end
        1: begin
          if (f_sel !== 1'b1 || f_wstrb !== op_wstrb[op_n-1] || f_addr !== op_addr[op_n-1])
            stab_err <= stab_err + 1;
          if (m_cnt == 0) begin
            f_ready <= 1'b1;
            m_phase <= 2;
            if (f_wstrb == 4'hF) m_last <= f_wdata;
            f_rdata <= (f_addr == corrupt_addr) ? ~m_last : m_last;
          end else begin
            m_cnt <= m_cnt - 1;
          end
        end
        default: m_phase <= 0;
      endcase
    end
  end

  // Cycle counter and event monitor.
  int cyc = 0;
  int done_cnt = 0, err_cnt = 0, ir_cnt = 0, sel_cnt = 0;
  int done_cyc = 0, err_cyc = 0, ready_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (done)    begin done_cnt++; done_cyc = cyc; end
    if (err)     begin err_cnt++;  err_cyc = cyc;  end
    if (in_ready) ir_cnt++;
    if (f_sel)    sel_cnt++;
    if (f_ready)  ready_cyc = cyc;
  end

  int start_cyc = 0;
  int gap_viol = 0;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_start(input logic [5:0] p, input logic [9:0] l);
    tick();
    start = 1'b1; page = p; len = l; start_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input int gap, output bit ok);
    ok = 1'b0;
    repeat (gap) begin
      tick();
      if (in_ready && f_sel) gap_viol++;
    end
    in_valid = 1'b1; in_data = d;
    for (int i = 0; i < 2000; i++) begin
      if (in_ready) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_end(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < GAP + 500; i++) begin
      tick();
      if (done || err) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    vec++; if ({busy, done, err, in_ready, f_sel} !== 5'b0) begin
      $display("FAIL reset_ctrl got %b want 00000", {busy, done, err, in_ready, f_sel}); miss++; end
    vec++; if ({err_code, f_wstrb, f_addr, f_wdata} !== 53'd0) begin
      $display("FAIL reset_bus got code=%0d wstrb=%h addr=%h wdata=%h want all 0", err_code, f_wstrb, f_addr, f_wdata); miss++; end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_program_two();
    int b, d0; bit ok;
    b = op_n; d0 = done_cnt;
    do_start(6'd3, 10'd2);
    send_word(32'hA5A5_0001, 0, ok);
    vec++; if (!ok) begin $display("FAIL p2_word0 accepted=%0d want 1", ok); miss++; end
    send_word(32'hA5A5_0002, 0, ok);
    vec++; if (!ok) begin $display("FAIL p2_word1 accepted=%0d want 1", ok); miss++; end
    wait_end(ok);
    vec++; if (done !== 1'b1 || err !== 1'b0) begin $display("FAIL p2_done done=%b err=%b want 1 0", done, err); miss++; end
    vec++; if (op_n - b !== 1 + 2 * VSTEP) begin $display("FAIL p2_opcount got %0d want %0d", op_n - b, 1 + 2 * VSTEP); miss++; end
    vec++; if (op_wstrb[b] !== 4'h1 || op_addr[b] !== 15'h0600) begin
      $display("FAIL p2_erase got wstrb=%h addr=%h want 1 0600", op_wstrb[b], op_addr[b]); miss++; end
    vec++; if (op_wstrb[b+1] !== 4'hF || op_addr[b+1] !== 15'h0600 || op_wdata[b+1] !== 32'hA5A5_0001) begin
      $display("FAIL p2_prog0 got %h %h %h want F 0600 a5a50001", op_wstrb[b+1], op_addr[b+1], op_wdata[b+1]); miss++; end
    vec++; if (op_wstrb[b+1+VSTEP] !== 4'hF || op_addr[b+1+VSTEP] !== 15'h0601 || op_wdata[b+1+VSTEP] !== 32'hA5A5_0002) begin
      $display("FAIL p2_prog1 got %h %h %h want F 0601 a5a50002", op_wstrb[b+1+VSTEP], op_addr[b+1+VSTEP], op_wdata[b+1+VSTEP]); miss++; end
    vec++; if (done_cyc - ready_cyc < GAP || done_cyc - ready_cyc > GAP + 2) begin
      $display("FAIL p2_cooldown got %0d clks want %0d..%0d", done_cyc - ready_cyc, GAP, GAP + 2); miss++; end
    vec++; if (err_code !== 2'd0 || done_cnt - d0 !== 1) begin
      $display("FAIL p2_status code=%0d dones=%0d want 0 1", err_code, done_cnt - d0); miss++; end
    tick();
    vec++; if (busy !== 1'b0) begin $display("FAIL p2_idle busy=%b want 0", busy); miss++; end
  endtask

  task automatic test_bad_page();
    int s0, b, e0, d0;
    s0 = sel_cnt; b = op_n; e0 = err_cnt; d0 = done_cnt;
    do_start(6'd38, 10'd1);
    vec++; if (busy !== 1'b1) begin $display("FAIL bp_busy1 got %b want 1", busy); miss++; end
    tick();
    vec++; if (err !== 1'b1 || err_cyc - start_cyc !== 2) begin
      $display("FAIL bp_errpulse err=%b delay=%0d want 1 2", err, err_cyc - start_cyc); miss++; end
    vec++; if (err_code !== 2'd1 || busy !== 1'b0 || done !== 1'b0) begin
      $display("FAIL bp_state code=%0d busy=%b done=%b want 1 0 0", err_code, busy, done); miss++; end
    tick();
    vec++; if (sel_cnt !== s0 || op_n !== b || err_cnt - e0 !== 1 || done_cnt !== d0) begin
      $display("FAIL bp_nobus sel=%0d ops=%0d errs=%0d dones=%0d want 0 0 1 0", sel_cnt - s0, op_n - b, err_cnt - e0, done_cnt - d0); miss++; end
  endtask

  task automatic test_bad_len();
    int b;
    b = op_n;
    do_start(6'd1, 10'd513);
    tick();
    vec++; if (err !== 1'b1 || err_code !== 2'd2) begin
      $display("FAIL bl_err err=%b code=%0d want 1 2", err, err_code); miss++; end
    tick();
    vec++; if (op_n !== b || busy !== 1'b0) begin
      $display("FAIL bl_nobus ops=%0d busy=%b want 0 0", op_n - b, busy); miss++; end
  endtask

  task automatic test_erase_only();
    int b, ir0; bit ok;
    b = op_n; ir0 = ir_cnt;
    do_start(6'd0, 10'd0);
    repeat (40) tick();
    vec++; if (busy !== 1'b1) begin $display("FAIL eo_cool_busy got %b want 1", busy); miss++; end
    do_start(6'd7, 10'd0);
    wait_end(ok);
    vec++; if (done !== 1'b1) begin $display("FAIL eo_done got %b want 1", done); miss++; end
    vec++; if (done_cyc - ready_cyc < GAP || done_cyc - ready_cyc > GAP + 2) begin
      $display("FAIL eo_cooldown got %0d clks want %0d..%0d", done_cyc - ready_cyc, GAP, GAP + 2); miss++; end
    start = 1'b1; page = 6'd9; len = 10'd0;
    tick();
    start = 1'b0;
    vec++; if (busy !== 1'b0) begin $display("FAIL eo_start_on_done busy=%b want 0", busy); miss++; end
    repeat (20) tick();
    vec++; if (op_n - b !== 1 || op_wstrb[b] !== 4'h1 || op_addr[b] !== 15'h0000) begin
      $display("FAIL eo_ops count=%0d wstrb=%h addr=%h want 1 1 0000", op_n - b, op_wstrb[b], op_addr[b]); miss++; end
    vec++; if (ir_cnt !== ir0 || busy !== 1'b0) begin
      $display("FAIL eo_noready in_ready_cycles=%0d busy=%b want 0 0", ir_cnt - ir0, busy); miss++; end
  endtask

  task automatic test_gaps();
    int b, nok; bit ok;
    b = op_n; nok = 0; gap_viol = 0;
    do_start(6'd5, 10'd4);
    for (int k = 0; k < 4; k++) begin
      send_word(32'h1111_0000 + 32'(k), 7, ok);
      if (!ok) nok++;
    end
    wait_end(ok);
    vec++; if (nok !== 0 || done !== 1'b1) begin $display("FAIL gp_flow rejects=%0d done=%b want 0 1", nok, done); miss++; end
    vec++; if (gap_viol !== 0) begin $display("FAIL gp_sel_in_gap got %0d want 0", gap_viol); miss++; end
    vec++; if (op_n - b !== 1 + 4 * VSTEP) begin $display("FAIL gp_opcount got %0d want %0d", op_n - b, 1 + 4 * VSTEP); miss++; end
    for (int k = 0; k < 4; k++) begin
      vec++;
      if (op_wstrb[b+1+k*VSTEP] !== 4'hF || op_addr[b+1+k*VSTEP] !== 15'h0A00 + 15'(k) ||
          op_wdata[b+1+k*VSTEP] !== 32'h1111_0000 + 32'(k)) begin
        $display("FAIL gp_prog%0d got %h %h %h want F %h %h", k, op_wstrb[b+1+k*VSTEP], op_addr[b+1+k*VSTEP],
                 op_wdata[b+1+k*VSTEP], 15'h0A00 + 15'(k), 32'h1111_0000 + 32'(k));
        miss++;
      end
    end
    vec++; if (stab_err !== 0) begin $display("FAIL gp_bus_stable got %0d changes want 0", stab_err); miss++; end
  endtask

`ifdef UFLASH_VERIFY_EN
  task automatic test_verify();
    int b, d0; bit ok;
    b = op_n; d0 = done_cnt;
    corrupt_addr = 15'h0401;
    do_start(6'd2, 10'd3);
    send_word(32'hC0DE_0000, 0, ok);
    send_word(32'hC0DE_0001, 0, ok);
    wait_end(ok);
    vec++; if (err !== 1'b1 || err_code !== 2'd3 || done_cnt !== d0) begin
      $display("FAIL vf_err err=%b code=%0d dones=%0d want 1 3 0", err, err_code, done_cnt - d0); miss++; end
    vec++; if (op_n - b !== 5 || op_wstrb[b+4] !== 4'h0 || op_addr[b+4] !== 15'h0401) begin
      $display("FAIL vf_ops count=%0d last=%h@%h want 5 0@0401", op_n - b, op_wstrb[b+4], op_addr[b+4]); miss++; end
    vec++; if (err_cyc - ready_cyc < GAP || err_cyc - ready_cyc > GAP + 2) begin
      $display("FAIL vf_cooldown got %0d want %0d..%0d", err_cyc - ready_cyc, GAP, GAP + 2); miss++; end
    corrupt_addr = 15'h7fff;
    tick();
  endtask
`endif

  task automatic test_reset_mid_prog();
    int b, d0, e0; bit ok, seen;
    do_start(6'd4, 10'd1);
    send_word(32'hDEAD_BEEF, 0, ok);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (f_sel && f_wstrb == 4'hF) begin seen = 1'b1; break; end
      tick();
    end
    vec++; if (!seen) begin $display("FAIL rm_reach_prog seen=%0d want 1", seen); miss++; end
    d0 = done_cnt; e0 = err_cnt;
    #2 reset_n = 1'b0;
    #1;
    vec++; if ({busy, in_ready, done, err, f_sel} !== 5'b0 || {err_code, f_wstrb, f_addr, f_wdata} !== 53'd0) begin
      $display("FAIL rm_async_clear ctrl=%b code=%0d wstrb=%h addr=%h wdata=%h want all 0",
               {busy, in_ready, done, err, f_sel}, err_code, f_wstrb, f_addr, f_wdata); miss++; end
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (3) tick();
    vec++; if (done_cnt !== d0 || err_cnt !== e0) begin
      $display("FAIL rm_silent dones=%0d errs=%0d want 0 0", done_cnt - d0, err_cnt - e0); miss++; end
    b = op_n;
    do_start(6'd6, 10'd0);
    wait_end(ok);
    vec++; if (done !== 1'b1 || op_n - b !== 1 || op_wstrb[b] !== 4'h1 || op_addr[b] !== 15'h0C00) begin
      $display("FAIL rm_restart done=%b ops=%0d wstrb=%h addr=%h want 1 1 1 0C00", done, op_n - b, op_wstrb[b], op_addr[b]); miss++; end
  endtask

  initial begin
    test_reset();
    test_program_two();
    test_bad_page();
    test_bad_len();
    test_erase_only();
    test_gaps();
`ifdef UFLASH_VERIFY_EN
    test_verify();
`endif
    test_reset_mid_prog();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
